data_input: RTL

Sequential BCD-to-binary input converter for the processor's `IN` path; the counterpart to the binary-to-BCD display path on the output side. It accepts up to eight BCD digits plus a sign flag from the board switches or keypad. It converts them to a 32-bit two's-complement value by reverse double dabble, one bit per clock. It presents the result on the processor's `entrada` bus with a start/busy/done handshake.

---
 rtl/data_io_pkg.sv | 15 +
 rtl/bcd_digit_adjust.sv | 9 +
 rtl/data_input.sv | 119 +++++++++++
 3 files changed

// File: rtl/data_io_pkg.sv
// Shared definitions for the processor's BCD input/output conversion paths.
package data_io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SHIFT = 2'd2,
    SIGN  = 2'd3
  } in_state_t;

  localparam int NDIG_DEF    = 8;
  localparam int DIG_MAX     = 9;
  localparam int SHIFT_ITERS = 32;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble correction for one BCD digit: d >= 8 becomes d - 3.
module bcd_digit_adjust (
  input  logic [3:0] i_d,
  output logic [3:0] o_d
);

  assign o_d = (i_d >= 4'd8) ? (i_d - 4'd3) : i_d;

endmodule

// File: rtl/data_input.sv
// Sequential BCD-to-binary converter for the IN path: reverse double dabble, one bit per clock.
// Handshake: start is sampled only in IDLE; busy is high from the accepting edge until done;
// done is a one-cycle pulse per accepted request; erro accompanies done on an invalid digit.
module data_input
  import data_io_pkg::*;
#(
  parameter int NDIG = NDIG_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  input  logic              neg,
  output logic [31:0]       valor,
  output logic              busy,
  output logic              done,
  output logic              erro,
  output in_state_t         state_dbg
);

  in_state_t         r_state;
  in_state_t         w_next;
  logic [4:0]        r_cnt;
  logic [4*NDIG-1:0] r_bcd;
  logic [31:0]       r_bin;
  logic              r_neg;
  logic [31:0]       r_valor;
  logic              r_done;
  logic              r_erro;

  logic [4*NDIG-1:0] w_bcd_shr;
  logic [4*NDIG-1:0] w_bcd_adj;
  logic [31:0]       w_bin_shr;
  logic              w_bad;
  logic              w_last;

  assign w_bcd_shr = r_bcd >> 1;
  assign w_bin_shr = {r_bcd[0], r_bin[31:1]};
  assign w_last    = (r_cnt == 5'(SHIFT_ITERS - 1));

  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_d (w_bcd_shr[4*g +: 4]),
      .o_d (w_bcd_adj[4*g +: 4])
    );
  end

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (r_bcd[4*i +: 4] > 4'(DIG_MAX)) w_bad = 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = CHECK;
      CHECK:   w_next = w_bad ? IDLE : SHIFT;
      SHIFT:   if (w_last) w_next = SIGN;
      SIGN:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_bin   <= '0;
      r_neg   <= 1'b0;
      r_valor <= '0;
      r_done  <= 1'b0;
      r_erro  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bcd  <= bcd_in;
            r_neg  <= neg;
            r_bin  <= '0;
            r_erro <= 1'b0;
            r_cnt  <= '0;
          end
        end
        CHECK: begin
          if (w_bad) begin
            r_erro <= 1'b1;
            r_done <= 1'b1;
          end
        end
        SHIFT: begin
          r_bcd <= w_bcd_adj;
          r_bin <= w_bin_shr;
          r_cnt <= r_cnt + 5'd1;
        end
        SIGN: begin
          // ~0 + 1 wraps to 0, so negative zero needs no special case.
          r_valor <= r_neg ? (~r_bin + 32'd1) : r_bin;
          r_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign valor     = r_valor;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign erro      = r_erro;
  assign state_dbg = r_state;

endmodule
